// File: rtl/tinker_muldiv_unit.sv
// Iterative integer multiply / divide / remainder unit, one bit per cycle.
// Issue and writeback each connect through a valid/ready handshake; a tag rides along with each op.
module tinker_muldiv_unit #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned TAG_W = 5,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             div_by_zero,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    localparam logic [1:0] OpDiv = 2'b01;
    localparam logic [1:0] OpRem = 2'b10;

    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               dbz_q, dbz_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic               in_is_divrem;
    logic               is_div, is_rem;
    logic [WIDTH:0]     trial, diff;
    logic               fits;
    logic [WIDTH-1:0]   mag;

    always_comb begin
        a_neg        = in_signed & in_a[WIDTH-1];
        b_neg        = in_signed & in_b[WIDTH-1];
        a_abs        = a_neg ? -in_a : in_a;
        b_abs        = b_neg ? -in_b : in_b;
        in_is_divrem = (in_op == OpDiv) || (in_op == OpRem);
        is_div       = (op_q == OpDiv);
        is_rem       = (op_q == OpRem);
        // Restoring step: shift next dividend bit into the partial remainder, then trial-subtract.
        trial        = {acc_q, a_q[WIDTH-1]};
        diff         = trial - {1'b0, b_q};
        fits         = ~diff[WIDTH];
        // Quotient accumulates in a_q; product and remainder both end up in acc_q.
        mag          = is_div ? a_q : acc_q;
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        neg_d   = neg_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        tag_d   = tag_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            StIdle: begin
                if (!flush && in_valid) begin
                    op_d  = in_op;
                    tag_d = in_tag;
                    a_d   = a_abs;
                    b_d   = b_abs;
                    acc_d = '0;
                    cnt_d = CNT_W'(WIDTH);
                    neg_d = (in_op == OpRem) ? a_neg : (a_neg ^ b_neg);
                    dbz_d = 1'b0;
                    if (in_is_divrem && (in_b == '0)) begin
                        state_d = StDone;
                        dbz_d   = 1'b1;
                        res_d   = (in_op == OpRem) ? in_a : '0;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    res_d   = neg_q ? -mag : mag;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (is_div || is_rem) begin
                        a_d   = {a_q[WIDTH-2:0], fits};
                        acc_d = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
                    end else begin
                        if (b_q[0]) begin
                            acc_d = acc_q + a_q;
                        end
                        a_d = a_q << 1;
                        b_d = b_q >> 1;
                    end
                end
            end
            StDone: begin
                if (flush || out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            op_q    <= '0;
            neg_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            tag_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            tag_q   <= tag_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready    = (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign out_valid   = (state_q == StDone);
    assign out_result  = res_q;
    assign out_tag     = tag_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_tinker_muldiv_unit.sv
// Scoreboard bench for tinker_muldiv_unit: directed corner cases plus randomized ops
// checked against an arithmetic reference model.
module tb_tinker_muldiv_unit;

    localparam int W  = 64;
    localparam int TW = 5;
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_op;
    logic          in_signed;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [TW-1:0] in_tag;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic [TW-1:0] out_tag;
    logic          div_by_zero;
    logic          busy;

    always #5 clk = ~clk;

    tinker_muldiv_unit #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_signed   (in_signed),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_tag      (in_tag),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_tag     (out_tag),
        .div_by_zero (div_by_zero),
        .busy        (busy)
    );

    typedef struct packed {
        logic [W-1:0]  res;
        logic [TW-1:0] tag;
        logic          dbz;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: plain language-level arithmetic, with the two architecturally defined corners.
    function automatic logic [W:0] model(input logic [1:0] op, input logic sgn,
                                         input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        logic [W-1:0]        r;
        logic                dz;
        sa = a;
        sb = b;
        dz = 1'b0;
        if (op == 2'b01 || op == 2'b10) begin
            if (b == '0) begin
                dz = 1'b1;
                if (op == 2'b01) r = '0;
                else r = a;
            end else if (sgn && a == MIN_NEG && b == '1) begin
                if (op == 2'b01) r = MIN_NEG;
                else r = '0;
            end else if (sgn) begin
                if (op == 2'b01) r = sa / sb;
                else r = sa % sb;
            end else begin
                if (op == 2'b01) r = a / b;
                else r = a % b;
            end
        end else begin
            r = a * b;
        end
        return {dz, r};
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual=%h required=no_output", out_result);
            end else begin
                e = sb_q.pop_front();
                check("sb_result", out_result, e.res);
                check("sb_tag", 64'(out_tag), 64'(e.tag));
                check("sb_dbz", 64'(div_by_zero), 64'(e.dbz));
            end
        end
    end

    // Called at posedge+1; returns at the accept edge +1.
    task automatic issue(input logic [1:0] op, input logic sgn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [TW-1:0] tag, input bit push,
                         input bit rnd_ready);
        int         n;
        logic [W:0] m;
        exp_t       e;
        n = 0;
        while (in_ready !== 1'b1 && n < 600) begin
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_wait actual=in_ready_%b required=in_ready_1", in_ready);
            return;
        end
        in_valid  = 1'b1;
        in_op     = op;
        in_signed = sgn;
        in_a      = a;
        in_b      = b;
        in_tag    = tag;
        if (push) begin
            m     = model(op, sgn, a, b);
            e.res = m[W-1:0];
            e.tag = tag;
            e.dbz = m[W];
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = {$urandom, $urandom};
        in_b     = {$urandom, $urandom};
        in_tag   = TW'($urandom);
    endtask

    task automatic wait_valid(input string name, output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (out_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=out_valid_%b required=out_valid_1", name, out_valid);
        end
    endtask

    function automatic logic [W-1:0] rand_val();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0: v = {$urandom, $urandom};
            1: v = W'($urandom_range(0, 20));
            2: v = MIN_NEG;
            3: v = '1;
            4: v = '0;
            default: v = -W'($urandom_range(1, 20));
        endcase
        return v;
    endfunction

    initial begin
        int lat;
        bit ok;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_signed = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        flush     = 1'b0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", out_result, '0);
        check("rst_tag", 64'(out_tag), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Latency of MUL 7*6 and in_ready low throughout
        issue(2'b00, 1'b0, 64'd7, 64'd6, 5'd3, 1'b1, 1'b0);
        lat = 0;
        ok  = 1'b1;
        while (out_valid !== 1'b1 && lat < 200) begin
            if (in_ready !== 1'b0) ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check("mul_latency", 64'(lat), 64'd65);
        check("mul_in_ready_low", 64'(ok), 64'd1);
        check("mul_result", out_result, 64'd42);
        check("mul_tag", 64'(out_tag), 64'd3);

        issue(2'b01, 1'b1, -64'd20, 64'd3, 5'd4, 1'b1, 1'b0);
        wait_valid("sdiv", lat);
        check("sdiv_result", out_result, 64'hFFFF_FFFF_FFFF_FFFA);
        issue(2'b10, 1'b1, -64'd20, 64'd3, 5'd5, 1'b1, 1'b0);
        wait_valid("srem", lat);
        check("srem_result", out_result, 64'hFFFF_FFFF_FFFF_FFFE);
        issue(2'b01, 1'b0, '1, 64'd2, 5'd6, 1'b1, 1'b0);
        wait_valid("udiv", lat);
        check("udiv_result", out_result, 64'h7FFF_FFFF_FFFF_FFFF);

        // Divide by zero
        issue(2'b01, 1'b0, 64'd100, 64'd0, 5'd7, 1'b1, 1'b0);
        wait_valid("dbz_div", lat);
        check("dbz_div_latency", 64'(lat), 64'd0);
        check("dbz_div_result", out_result, 64'd0);
        check("dbz_div_flag", 64'(div_by_zero), 64'd1);
        issue(2'b10, 1'b0, 64'd100, 64'd0, 5'd8, 1'b1, 1'b0);
        wait_valid("dbz_rem", lat);
        check("dbz_rem_result", out_result, 64'd100);
        check("dbz_rem_flag", 64'(div_by_zero), 64'd1);

        // Backpressure hold in DONE
        issue(2'b01, 1'b1, -64'd20, 64'd3, 5'd9, 1'b1, 1'b0);
        out_ready = 1'b0;
        wait_valid("hold", lat);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_tag !== 5'd9 ||
                out_result !== 64'hFFFF_FFFF_FFFF_FFFA || div_by_zero !== 1'b0) ok = 1'b0;
            @(posedge clk);
            #1;
        end
        check("hold_stable", 64'(ok), 64'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hold_release_in_ready", 64'(in_ready), 64'd1);
        check("hold_release_out_valid", 64'(out_valid), 64'd0);

        // Flush on the 20th CALC cycle
        issue(2'b00, 1'b0, 64'd12345, 64'd999, 5'd10, 1'b0, 1'b0);
        repeat (19) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_busy", 64'(busy), 64'd0);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (out_valid === 1'b1) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        check("flush_no_valid", 64'(ok), 64'd0);
        issue(2'b00, 1'b0, MIN_NEG, 64'd2, 5'd11, 1'b1, 1'b0);
        wait_valid("mul_wrap", lat);
        check("mul_wrap_result", out_result, 64'd0);
        issue(2'b11, 1'b0, 64'h1234, 64'h10, 5'd12, 1'b1, 1'b0);
        wait_valid("op11", lat);
        check("op11_result", out_result, 64'h12340);

        // Asynchronous reset mid-CALC
        issue(2'b00, 1'b0, 64'd555, 64'd777, 5'd13, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_result", out_result, '0);
        check("arst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        issue(2'b01, 1'b1, MIN_NEG, '1, 5'd14, 1'b1, 1'b0);
        wait_valid("ovf_div", lat);
        check("ovf_div_result", out_result, MIN_NEG);
        check("ovf_div_dbz", 64'(div_by_zero), 64'd0);
        issue(2'b10, 1'b1, MIN_NEG, '1, 5'd15, 1'b1, 1'b0);
        wait_valid("ovf_rem", lat);
        check("ovf_rem_result", out_result, 64'd0);

        // Randomized ops with random writeback backpressure
        for (int i = 0; i < 40; i++) begin
            issue(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rand_val(), rand_val(),
                  TW'($urandom), 1'b1, 1'b1);
        end
        out_ready = 1'b1;
        lat = 0;
        while (sb_q.size() != 0 && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("drain_empty", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
